// File: rtl/dco_tw_dither.sv
// Sigma-delta dither of a fixed-point tuning word into a saturated WORD_W-bit word plus update strobe.
// Define DCO_MASH2_EN for the second-order MASH 1-1 modulator; first-order otherwise.
module dco_tw_dither #(
    parameter int unsigned WORD_W = 8,
    parameter int unsigned FRAC_W = 8,
    parameter int unsigned DIV_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tw_valid,
    input  logic [WORD_W-1:0] tw_int,
    input  logic [FRAC_W-1:0] tw_frac,
    input  logic [DIV_W-1:0]  div,
    input  logic              freeze,
    output logic [WORD_W-1:0] word,
    output logic              en,
    output logic              sat_hi,
    output logic              sat_lo
);

    localparam int unsigned SUM_W = WORD_W + 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_tick;
    logic               w_run;

    logic [DIV_W-1:0]   r_cnt;
    logic [WORD_W-1:0]  r_int_h;
    logic [FRAC_W-1:0]  r_frac_h;
    logic [FRAC_W-1:0]  r_acc1;
    logic [WORD_W-1:0]  r_word;
    logic               r_en;
    logic               r_sat_hi;

    logic [FRAC_W:0]    w_sum1;
    logic               w_c1;
    logic [FRAC_W-1:0]  w_acc1_nxt;
    logic signed [SUM_W-1:0] w_s;
    logic               w_neg;
    logic               w_ovf;
    logic [WORD_W-1:0]  w_word_nxt;

`ifdef DCO_MASH2_EN
    logic [FRAC_W-1:0]  r_acc2;
    logic               r_c2_d;
    logic               r_sat_lo;
    logic [FRAC_W:0]    w_sum2;
    logic               w_c2;
    logic [FRAC_W-1:0]  w_acc2_nxt;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A shrinking div can leave cnt above it; >= turns that into an immediate tick.
    always_comb begin
        w_state_nxt = r_state;
        w_tick      = 1'b0;
        case (r_state)
            ST_IDLE: if (tw_valid) w_state_nxt = ST_RUN;
            ST_RUN:  w_tick = !freeze && (r_cnt >= div);
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_run = (r_state == ST_RUN);

    always_comb begin
        w_sum1     = {1'b0, r_acc1} + {1'b0, r_frac_h};
        w_c1       = w_sum1[FRAC_W];
        w_acc1_nxt = w_sum1[FRAC_W-1:0];
`ifdef DCO_MASH2_EN
        w_sum2     = {1'b0, r_acc2} + {1'b0, w_acc1_nxt};
        w_c2       = w_sum2[FRAC_W];
        w_acc2_nxt = w_sum2[FRAC_W-1:0];
        w_s        = {2'b00, r_int_h}
                   + {{(SUM_W-1){1'b0}}, w_c1}
                   + {{(SUM_W-1){1'b0}}, w_c2}
                   - {{(SUM_W-1){1'b0}}, r_c2_d};
`else
        w_s        = {2'b00, r_int_h} + {{(SUM_W-1){1'b0}}, w_c1};
`endif
        w_neg = w_s[SUM_W-1];
        w_ovf = !w_neg && w_s[WORD_W];
        if (w_neg) begin
            w_word_nxt = '0;
        end else if (w_ovf) begin
            w_word_nxt = '1;
        end else begin
            w_word_nxt = w_s[WORD_W-1:0];
        end
    end

    // The tick consumes the hold registers' pre-load values when tw_valid lands on a tick edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt    <= '0;
            r_int_h  <= '0;
            r_frac_h <= '0;
            r_acc1   <= '0;
            r_word   <= '0;
            r_en     <= 1'b0;
            r_sat_hi <= 1'b0;
`ifdef DCO_MASH2_EN
            r_acc2   <= '0;
            r_c2_d   <= 1'b0;
            r_sat_lo <= 1'b0;
`endif
        end else begin
            if (tw_valid) begin
                r_int_h  <= tw_int;
                r_frac_h <= tw_frac;
            end
            r_en     <= 1'b0;
            r_sat_hi <= 1'b0;
`ifdef DCO_MASH2_EN
            r_sat_lo <= 1'b0;
`endif
            if (w_run && !freeze) begin
                if (w_tick) begin
                    r_cnt    <= '0;
                    r_acc1   <= w_acc1_nxt;
                    r_word   <= w_word_nxt;
                    r_en     <= 1'b1;
                    r_sat_hi <= w_ovf;
`ifdef DCO_MASH2_EN
                    r_acc2   <= w_acc2_nxt;
                    r_c2_d   <= w_c2;
                    r_sat_lo <= w_neg;
`endif
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign word   = r_word;
    assign en     = r_en;
    assign sat_hi = r_sat_hi;
`ifdef DCO_MASH2_EN
    assign sat_lo = r_sat_lo;
`else
    assign sat_lo = 1'b0;
`endif

endmodule

// File: tb/tb_dco_tw_dither.sv
// Scoreboard bench for dco_tw_dither: a per-edge reference model queues expected updates,
// a negedge monitor pops and compares them whenever en is presented.
module tb_dco_tw_dither;

    localparam int WORD_W = 8;
    localparam int FRAC_W = 8;
    localparam int DIV_W  = 4;
    localparam longint FS   = longint'(1) << FRAC_W;
    localparam int     WMAX = (1 << WORD_W) - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              tw_valid;
    logic [WORD_W-1:0] tw_int;
    logic [FRAC_W-1:0] tw_frac;
    logic [DIV_W-1:0]  div;
    logic              freeze;
    logic [WORD_W-1:0] word;
    logic              en;
    logic              sat_hi;
    logic              sat_lo;

    always #5 clk = ~clk;

    dco_tw_dither #(
        .WORD_W(WORD_W),
        .FRAC_W(FRAC_W),
        .DIV_W (DIV_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .tw_valid(tw_valid),
        .tw_int  (tw_int),
        .tw_frac (tw_frac),
        .div     (div),
        .freeze  (freeze),
        .word    (word),
        .en      (en),
        .sat_hi  (sat_hi),
        .sat_lo  (sat_lo)
    );

    typedef struct {
        int due;
        int word;
        bit hi;
        bit lo;
    } exp_t;

    exp_t q[$];
    int   n_edge = 0;
    int   errors = 0;
    int   checks = 0;
    bit   mon_on = 1'b0;

    // Reference model: ideal accumulated fractional sums, carries taken as floor differences.
    bit     m_run;
    int     m_phase;
    longint m_f1, m_f2;
    int     m_c2d;
    int     m_int, m_frac;

    bit     dwin = 1'b0;
    int     dsum = 0;
    int     dcnt = 0;

    function automatic void model_edge(input int due);
        int     c1, c2, d, s;
        longint a1;
        exp_t   e;
        if (!rst) begin
            m_run = 1'b0; m_phase = 0; m_f1 = 0; m_f2 = 0; m_c2d = 0;
            m_int = 0; m_frac = 0;
            return;
        end
        if (m_run && !freeze) begin
            if (m_phase >= int'(div)) begin
                c1 = int'((m_f1 + m_frac) / FS - m_f1 / FS);
                a1 = (m_f1 + m_frac) % FS;
                m_f1 = m_f1 + m_frac;
`ifdef DCO_MASH2_EN
                c2 = int'((m_f2 + a1) / FS - m_f2 / FS);
                m_f2 = m_f2 + a1;
                d = c1 + c2 - m_c2d;
                m_c2d = c2;
`else
                c2 = 0;
                d = c1 + c2;
`endif
                s = m_int + d;
                e.due = due;
                e.hi  = (s > WMAX);
                e.lo  = (s < 0);
                e.word = e.hi ? WMAX : (e.lo ? 0 : s);
                q.push_back(e);
                m_phase = 0;
            end else begin
                m_phase++;
            end
        end
        if (tw_valid) begin
            m_int  = int'(tw_int);
            m_frac = int'(tw_frac);
            m_run  = 1'b1;
        end
    endfunction

    task automatic step();
        model_edge(n_edge + 1);
        @(posedge clk);
        n_edge++;
        #1;
    endtask

    task automatic check_reset();
        checks++;
        if (word !== '0 || en !== 1'b0 || sat_hi !== 1'b0 || sat_lo !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: word=%0d en=%b sat_hi=%b sat_lo=%b, required all 0",
                     word, en, sat_hi, sat_lo);
        end
    endtask

    task automatic reset_pulse();
        rst = 1'b0; tw_valid = 1'b0; freeze = 1'b0;
        step();
        check_reset();
        rst = 1'b1;
    endtask

    task automatic capture(input int iv, input int fv, input int dv);
        div = DIV_W'(dv); tw_int = WORD_W'(iv); tw_frac = FRAC_W'(fv); tw_valid = 1'b1;
        step();
        tw_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (mon_on) begin
            if (en === 1'b1) begin
                if (dwin) begin
                    dsum += (sat_lo === 1'b1) ? -1 : int'(word);
                    dcnt++;
                end
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_en: en=1 after edge %0d, required no update", n_edge);
                end else begin
                    e = q.pop_front();
                    if (e.due != n_edge) begin
                        errors++;
                        $display("FAIL en_timing: en after edge %0d, required after edge %0d",
                                 n_edge, e.due);
                    end
                    checks++;
                    if (int'(word) != e.word) begin
                        errors++;
                        $display("FAIL word: got %0d, required %0d (edge %0d)", word, e.word, n_edge);
                    end
                    checks++;
                    if (sat_hi !== e.hi || sat_lo !== e.lo) begin
                        errors++;
                        $display("FAIL sat_flags: got hi=%b lo=%b, required hi=%b lo=%b (edge %0d)",
                                 sat_hi, sat_lo, e.hi, e.lo, n_edge);
                    end
                end
            end else begin
                checks++;
                if (en !== 1'b0 || sat_hi !== 1'b0 || sat_lo !== 1'b0) begin
                    errors++;
                    $display("FAIL idle_outputs: en=%b sat_hi=%b sat_lo=%b, required all 0",
                             en, sat_hi, sat_lo);
                end
                while (q.size() > 0 && q[0].due <= n_edge) begin
                    e = q.pop_front();
                    errors++;
                    $display("FAIL missing_en: no en after edge %0d, required word %0d", n_edge, e.word);
                end
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached, required bench completion");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    initial begin
        rst = 1'b0; tw_valid = 1'b0; freeze = 1'b0;
        tw_int = '0; tw_frac = '0; div = '0;
        step();
        step();
        check_reset();
        mon_on = 1'b1;
        rst = 1'b1;

        // First-order rate: expect 10,10,10,11 repeating, en every cycle.
        capture(10, 8'h40, 0);
        repeat (16) step();

        // Divider period 4 with a 5-cycle freeze mid-period.
        reset_pulse();
        capture(100, 8'h33, 3);
        repeat (6) step();
        freeze = 1'b1;
        repeat (5) step();
        freeze = 1'b0;
        repeat (12) step();

        // High saturation.
        reset_pulse();
        capture(255, 8'h80, 0);
        repeat (12) step();

        // Hold/update collision on a tick edge.
        reset_pulse();
        capture(20, 8'h00, 2);
        for (int i = 0; i < 8 && m_phase < int'(div); i++) step();
        tw_int = 8'd30; tw_valid = 1'b1;
        step();
        tw_valid = 1'b0;
        repeat (9) step();

`ifdef DCO_MASH2_EN
        // Low saturation; mean dither over 256 ticks must be 1/256.
        reset_pulse();
        capture(0, 8'h01, 0);
        dwin = 1'b1;
        repeat (255) step();
        @(negedge clk);
        #1;
        dwin = 1'b0;
        checks++;
        if (dcnt != 256 || dsum != 1) begin
            errors++;
            $display("FAIL mash_mean: got sum=%0d over %0d ticks, required sum=1 over 256", dsum, dcnt);
        end
        repeat (4) step();
`endif

        // Reset mid-run, then idle with no capture, then restart.
        reset_pulse();
        capture(50, 8'h10, 1);
        repeat (7) step();
        rst = 1'b0;
        step();
        check_reset();
        rst = 1'b1;
        repeat (6) step();
        capture(60, 8'h90, 2);
        repeat (10) step();

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            rst      = ($urandom_range(0, 299) != 0);
            tw_valid = ($urandom_range(0, 9) == 0);
            freeze   = ($urandom_range(0, 7) == 0);
            case ($urandom_range(0, 3))
                0:       tw_int = WORD_W'(WMAX - $urandom_range(0, 1));
                1:       tw_int = WORD_W'($urandom_range(0, 1));
                default: tw_int = WORD_W'($urandom);
            endcase
            tw_frac = FRAC_W'($urandom);
            if ($urandom_range(0, 49) == 0) div = DIV_W'($urandom_range(0, 5));
            step();
            if (!rst) check_reset();
        end

        rst = 1'b1; tw_valid = 1'b0; freeze = 1'b0;
        repeat (8) step();
        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d expected updates left, required 0", q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dco_tw_dither.md
# dco_tw_dither

Tuning-word dither stage that sits directly upstream of the DCO row/column thermometer coder. It accepts a fixed-point tuning word from the loop filter: an integer part plus a fractional part. A sigma-delta modulator turns the fractional part into a time-averaged ±LSB dither on the integer part. The block emits a saturated `WORD_W`-bit binary word with a one-cycle update strobe, and the coder consumes these directly as its `word` and `en`.

## Interface
- `WORD_W`, 8: width of the integer tuning part and of the output word. Must equal the downstream coder's `WORD_W`.
- `FRAC_W`, 8: width of the fractional tuning part and of each sigma-delta accumulator.
- `DIV_W`, 4: width of the dither-rate divider setting.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: reset, synchronous and active-low.
- `tw_valid` in 1: high for one or more cycles; captures `tw_int`/`tw_frac` at each rising `clk` edge.
- `tw_int` in `WORD_W`: integer tuning part, unsigned.
- `tw_frac` in `FRAC_W`: fractional tuning part, unsigned, weight 2^-`FRAC_W`.
- `div` in `DIV_W`: dither update period minus 1, in clocks. Sampled every cycle.
- `freeze` in 1: holds the divider and the modulator.
- `word` out `WORD_W`: dithered, saturated word.
- `en` out 1: one-cycle strobe marking a new `word`.
- `sat_hi` out 1: valid with `en`; high when the sum exceeded 2^`WORD_W`-1 and was clamped.
- `sat_lo` out 1: valid with `en`; high when the sum was below 0 and was clamped.

## Operation
- Hold registers:
  - `int_h` and `frac_h` load on every edge with `tw_valid`=1.
  - At the same edge, the tick step uses the pre-load values.
- State machine:
  - IDLE: after reset. Divider held at 0, no ticks, `en`=0.
  - IDLE→RUN on the first edge with `tw_valid`=1. The divider is 0 entering RUN.
  - RUN persists until reset.
- Divider, in RUN with `freeze`=0:
  - A cycle with `cnt`==`div` is a tick cycle; `cnt`→0 at that edge.
  - Otherwise `cnt` increments.
  - If `div` shrinks below `cnt`, treat `cnt`≥`div` as a tick.
  - With `freeze`=1: `cnt`, accumulators and outputs hold, `en`=0.
- First-order step, on a tick:
  - `acc1` ← (`acc1`+`frac_h`) mod 2^`FRAC_W`.
  - `c1` = carry out.
  - Dither d = `c1` ∈ {0,1}.
- Sum and saturation:
  - s = `int_h` + d, computed signed at `WORD_W`+2 bits.
  - s>2^`WORD_W`-1 → `word`=2^`WORD_W`-1, `sat_hi`=1.
  - s<0 → `word`=0, `sat_lo`=1.
  - Otherwise `word`=s and both flags are 0.
- Non-tick cycles: `word` holds; `en`, `sat_hi`, `sat_lo` are 0.
- `tw_frac`=0 with accumulators at 0: d=0 permanently and `word`=`int_h`.

## Timing
- Reset (`rst`=0 at an edge) drives:
  - `word`=0, `en`=0, `sat_hi`=0, `sat_lo`=0.
  - `cnt`=0, `acc1`=`acc2`=0, `c2_d`=0, `int_h`=`frac_h`=0, state IDLE.
  - Reset overrides `tw_valid` and `freeze` in the same cycle.
  - Reset mid-run discards all modulator state. The next `tw_valid` restarts from IDLE behaviour.
- Latency:
  - Capture edge E0 (IDLE→RUN). The first tick is the cycle following edge E0+`div`.
  - Outputs register at the tick edge E0+`div`+1. `en` is high for the cycle after that edge.
  - Steady state: one `en` every `div`+1 cycles. With `div`=0, `en` is continuously high.
- A new `tw_valid` captured at edge Ek first affects `word` at the next tick edge strictly after Ek.
- Output changes only at tick edges, one register stage after the sum. There is no combinational path from inputs to outputs.

## Configuration
- `DCO_MASH2_EN` defined: second-order MASH 1-1.
  - Per tick: `acc2` ← (`acc2`+`acc1`new) mod 2^`FRAC_W`, carry `c2`.
  - d = `c1` + `c2` − `c2_d`, with d ∈ {−1..+2}.
  - `c2_d` ← `c2`.
  - Saturation as above; `sat_lo` is reachable only in this mode.
- Undefined: first-order only. `acc2`/`c2_d` are absent and `sat_lo` is tied to 0.

## Test plan
- First-order rate: `div`=0, capture `tw_int`=10, `tw_frac`=0x40 → `word` repeats 10,10,10,11; `en` high every cycle; flags 0.
- Divider and freeze: `div`=3 → `en` pulses every 4 cycles. Assert `freeze` for 5 cycles mid-period → no `en`, and the phase resumes where it stopped.
- High saturation: `tw_int`=255, `tw_frac`=0x80, `div`=0 → `word`=255 always; `sat_hi`=1 on every second `en`.
- Low saturation (`DCO_MASH2_EN`): `tw_int`=0, `tw_frac`=0x01, `div`=0 → `word` ∈ {0,1,2}; `sat_lo`=1 whenever d=−1. Over 256 ticks, mean d×256 = 1.
- Hold/update collision: `tw_valid` on a tick edge with `tw_int` changing 20→30 (`tw_frac`=0, `div`=2) → that tick outputs 20; the next tick outputs 30.
- Reset mid-run: `rst`=0 for one cycle during RUN → next cycle all outputs 0, state IDLE. No `en` until `tw_valid`, then the first `en` arrives `div`+1 edges after capture.
